pwm_angle_capture: RTL
======================

Name: pwm_angle_capture

Overview:
- Servo-PWM receiver/decoder: the reverse of the angle-to-PWM path that drives the arm servos.
- Samples one 50 Hz servo PWM line, measures high time and period at 50 MHz, validates the frame, and converts the pulse width to a Q16.16 angle in degrees (0 to 180).
- Used for loop-back checking of the arm's servo outputs and for reading positions from external servo controllers.

Parameters:
- MIN_CNT, 25000: high-time cycles for 0 deg (0.5 ms).
- MAX_CNT, 125000: high-time cycles for 180 deg (2.5 ms).
- PER_MIN, 900000: minimum legal period in cycles (18 ms).
- PER_MAX, 1100000: maximum legal period in cycles (22 ms).
- TIMEOUT, 1500000: cycles with no rising edge before a timeout is declared.
- SCALE, 7730941: round(180*2^32/(MAX_CNT-MIN_CNT)).

Ports:
- clk  in  1  50 MHz clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pwm_in  in  1  asynchronous servo PWM input.
- angle  out  32  Q16.16 degrees, held between updates.
- valid  out  1  one-cycle pulse when angle updates.
- range_err  out  1  last frame's high time was outside [MIN_CNT, MAX_CNT]; angle clamped.
- period_err  out  1  last frame's period was outside [PER_MIN, PER_MAX]; angle not updated.
- timeout  out  1  level; no rising edge seen for TIMEOUT cycles.

Behaviour:
- Reset: angle=0, valid=0, range_err=0, period_err=0, timeout=0, FSM=IDLE, all counters 0.
- Input conditioning: 2-FF synchronizer, then edge register. rise = s & ~s_d; fall = ~s & s_d.
- FSM states:
  - IDLE: wait for rise. On rise: clear hi_cnt and per_cnt to 1, go to HIGH.
  - HIGH: hi_cnt++ and per_cnt++ each cycle. On fall: go to LOW.
  - LOW: per_cnt++. On rise: latch hi_cnt and per_cnt into the frame registers, restart both counters at 1, go to HIGH, and fire the conversion pipeline.
- Counters are 21 bits and saturate at all-ones. No wrap-around.
- Timeout:
  - A watchdog counts cycles since the last rise. When it reaches TIMEOUT: timeout=1, FSM to IDLE, no valid.
  - timeout clears on the next rise.
  - A stuck-high input (no fall) also times out, because no rise occurs.
- Frame check, applied when the frame is latched:
  - per outside [PER_MIN, PER_MAX]: period_err=1, no valid, angle unchanged.
  - Otherwise period_err=0, then:
  - hi < MIN_CNT: delta=0, range_err=1.
  - hi > MAX_CNT: delta=MAX_CNT-MIN_CNT, range_err=1.
  - Otherwise delta=hi-MIN_CNT, range_err=0.
- Conversion arithmetic: angle = (delta*SCALE + 2^15) >> 16, using a 17x23 to 40-bit product truncated to 32 bits.
- Latency: stage 1 registers delta and the flags; stage 2 registers the product; stage 3 registers angle with valid=1.
  - valid therefore asserts exactly 3 clocks after the cycle in which the closing rise is detected.
  - Flags update in the same cycle as valid, or on the would-be valid cycle for period_err.
- The first rise after reset or timeout only opens a frame. The first valid needs a second rise.
- A rise during a pipeline in flight is legal. Frames are at least PER_MIN apart.
- Reset mid-frame aborts everything immediately and clears all outputs.

Optional Feature:
- Macro: PWM_CAPTURE_AVG_EN.
- Defined:
  - delta passes through a 4-entry moving average: sum of the last 4 accepted deltas >> 2.
  - Entries fill from reset or timeout. Until 4 entries exist, divide by the entry count, 1, 2 or 4. With 3 entries, use the sum of the first 2 duplicated.
  - Adds 1 cycle of latency, so valid is 4 clocks after rise.
  - Period-error frames are not entered.
- Undefined: no averaging, latency 3.

Decomposition:
- Shared header pwm_capture_defs.vh holds:
  - default MIN_CNT, MAX_CNT, PER_MIN, PER_MAX, TIMEOUT;
  - Q16.16 constants ANG_0=32'h0000_0000, ANG_90=32'h005A_0000, ANG_180=32'h00B4_0000;
  - FSM state encodings IDLE/HIGH/LOW.
- One sub-module, pwm_angle_conv: delta in, registered multiply, round, shift, angle out. Contains the stage 2 and 3 pipeline.

Test Plan:
- 20 ms period, 1.5 ms high (75000 cycles), 3 frames: angle=32'h005A_0000; valid 3 clks after each closing rise; first frame produces no valid.
- High 0.5 ms and 2.5 ms: angle=32'h0000_0000 and 32'h00B4_0000, range_err=0. High 1.0 ms (50000) gives 32'h002D_0000.
- High 0.3 ms and 2.8 ms: angle clamped to 0 and 32'h00B4_0000, range_err=1. The next 1.5 ms frame clears range_err.
- Period 15 ms with 1.5 ms high: period_err=1, no valid, angle keeps its prior value. A following 20 ms frame produces valid and clears period_err.
- Input held low 40 ms, and separately held high 40 ms: timeout=1 at TIMEOUT cycles after the last rise, FSM in IDLE; the next rise clears timeout.
- rst_n low mid-HIGH: outputs 0 at once. After release, 2 frames are needed before valid. With PWM_CAPTURE_AVG_EN, deltas 25000/75000 average to 50000, giving angle 32'h005A_0000.

Source files
------------

// File: rtl/pwm_angle_capture_pkg.sv
// Shared definitions for the servo PWM capture path: default timing constants,
// Q16.16 reference angles, FSM state encoding and the frame-flag payload.
package pwm_angle_capture_pkg;

  localparam int unsigned CNT_W = 21;
  localparam int unsigned ANG_W = 32;

  localparam int unsigned     DEF_MIN_CNT = 25000;
  localparam int unsigned     DEF_MAX_CNT = 125000;
  localparam int unsigned     DEF_PER_MIN = 900000;
  localparam int unsigned     DEF_PER_MAX = 1100000;
  localparam int unsigned     DEF_TIMEOUT = 1500000;
  localparam longint unsigned DEF_SCALE   = 64'd7730941;

  localparam logic [ANG_W-1:0] ANG_0   = 32'h0000_0000;
  localparam logic [ANG_W-1:0] ANG_90  = 32'h005A_0000;
  localparam logic [ANG_W-1:0] ANG_180 = 32'h00B4_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic range_err;
    logic period_err;
  } frame_flags_t;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pwm_angle_capture_if.sv
// PWM input plus decoded angle/status bundle of the capture block.
interface pwm_angle_capture_if;
  import pwm_angle_capture_pkg::*;

  logic             pwm_in;
  logic [ANG_W-1:0] angle;
  logic             valid;
  logic             range_err;
  logic             period_err;
  logic             timeout;

  modport master (input pwm_in, output angle, valid, range_err, period_err, timeout);
  modport slave  (output pwm_in, input angle, valid, range_err, period_err, timeout);
endinterface

// File: rtl/pwm_angle_conv.sv
// Pulse-width delta to Q16.16 degrees: registered multiply, then round/shift
// into the held output registers. Period-error frames only update period_err.
module pwm_angle_conv
  import pwm_angle_capture_pkg::*;
#(
  parameter int unsigned     DELTA_W = 17,
  parameter longint unsigned SCALE   = DEF_SCALE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_vld,
  input  logic [DELTA_W-1:0] i_delta,
  input  frame_flags_t       i_flags,
  output logic [ANG_W-1:0]   o_angle,
  output logic               o_valid,
  output logic               o_range_err,
  output logic               o_period_err
);

  localparam int unsigned SCALE_W = $clog2(SCALE + 64'd1);
  localparam int unsigned PROD_W  = DELTA_W + SCALE_W;
  localparam logic [PROD_W-1:0] SCALE_V = PROD_W'(SCALE);
  localparam logic [PROD_W-1:0] RND     = PROD_W'(64'd1 << 15);

  logic [PROD_W-1:0] r_prod;
  logic              r_s2_vld;
  frame_flags_t      r_s2_flags;
  logic [PROD_W-1:0] w_rnd;
  logic [ANG_W-1:0]  w_angle;

  assign w_rnd   = r_prod + RND;
  assign w_angle = ANG_W'(w_rnd >> 16);

  // Stage 2: product of delta and the degrees-per-cycle scale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_flags <= '0;
    end else begin
      r_s2_vld   <= i_vld;
      r_s2_flags <= i_flags;
      if (i_vld) r_prod <= PROD_W'(i_delta) * SCALE_V;
    end
  end

  // Stage 3: rounded angle and flags; angle holds across bad-period frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_angle      <= '0;
      o_valid      <= 1'b0;
      o_range_err  <= 1'b0;
      o_period_err <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r_s2_vld) begin
        if (r_s2_flags.period_err) begin
          o_period_err <= 1'b1;
        end else begin
          o_period_err <= 1'b0;
          o_range_err  <= r_s2_flags.range_err;
          o_angle      <= w_angle;
          o_valid      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_angle_capture.sv
// Servo PWM receiver: synchronises the input, measures high time and period,
// validates the frame and converts the width to a Q16.16 angle (0..180 deg).
// Optional macro PWM_CAPTURE_AVG_EN adds a 4-entry moving average on delta
// (one extra cycle of latency).
module pwm_angle_capture
  import pwm_angle_capture_pkg::*;
#(
  parameter int unsigned     MIN_CNT = DEF_MIN_CNT,
  parameter int unsigned     MAX_CNT = DEF_MAX_CNT,
  parameter int unsigned     PER_MIN = DEF_PER_MIN,
  parameter int unsigned     PER_MAX = DEF_PER_MAX,
  parameter int unsigned     TIMEOUT = DEF_TIMEOUT,
  parameter longint unsigned SCALE   = DEF_SCALE
) (
  input logic                 clk,
  input logic                 rst_n,
  pwm_angle_capture_if.master io_bus
);

  localparam int unsigned SPAN    = MAX_CNT - MIN_CNT;
  localparam int unsigned DELTA_W = $clog2(SPAN + 1);

  logic               r_meta, r_sync, r_sync_d;
  logic               w_rise, w_fall;
  state_e             r_state;
  logic [CNT_W-1:0]   r_hi_cnt, r_per_cnt, r_wd;
  logic               r_timeout;
  logic               w_to_hit, w_close;
  logic [DELTA_W-1:0] w_s1_delta, r_s1_delta;
  frame_flags_t       w_s1_flags, r_s1_flags;
  logic               r_s1_vld;
  logic               w_cv_vld;
  logic [DELTA_W-1:0] w_cv_delta;
  frame_flags_t       w_cv_flags;

  assign w_rise   = r_sync & ~r_sync_d;
  assign w_fall   = ~r_sync & r_sync_d;
  assign w_to_hit = ~w_rise & (r_wd == CNT_W'(TIMEOUT - 1));
  assign w_close  = (r_state == ST_LOW) & w_rise;

  // Two-flop synchroniser followed by the edge-detect register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_meta   <= io_bus.pwm_in;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
    end
  end

  // Watchdog: cycles since the last rise; saturates once the timeout fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else if (w_rise) begin
      r_wd      <= CNT_W'(1);
      r_timeout <= 1'b0;
    end else begin
      if (r_wd < CNT_W'(TIMEOUT)) r_wd <= r_wd + CNT_W'(1);
      if (w_to_hit) r_timeout <= 1'b1;
    end
  end

  // Frame FSM: rise opens a frame, fall ends the high phase, next rise closes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hi_cnt  <= '0;
      r_per_cnt <= '0;
    end else if (w_to_hit) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_hi_cnt  <= CNT_W'(1);
            r_per_cnt <= CNT_W'(1);
            r_state   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          r_per_cnt <= sat_inc(r_per_cnt);
          if (w_fall) r_state  <= ST_LOW;
          else        r_hi_cnt <= sat_inc(r_hi_cnt);
        end
        ST_LOW: begin
          if (w_rise) begin
            r_hi_cnt  <= CNT_W'(1);
            r_per_cnt <= CNT_W'(1);
            r_state   <= ST_HIGH;
          end else begin
            r_per_cnt <= sat_inc(r_per_cnt);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Frame check on the live counters so stage 1 captures them at the closing rise
  always_comb begin
    w_s1_delta            = '0;
    w_s1_flags            = '0;
    w_s1_flags.period_err = (r_per_cnt < CNT_W'(PER_MIN)) || (r_per_cnt > CNT_W'(PER_MAX));
    if (r_hi_cnt < CNT_W'(MIN_CNT)) begin
      w_s1_flags.range_err = 1'b1;
    end else if (r_hi_cnt > CNT_W'(MAX_CNT)) begin
      w_s1_delta           = DELTA_W'(SPAN);
      w_s1_flags.range_err = 1'b1;
    end else begin
      w_s1_delta = DELTA_W'(r_hi_cnt - CNT_W'(MIN_CNT));
    end
  end

  // Stage 1: frame registers (clamped delta and flags)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_delta <= '0;
      r_s1_flags <= '0;
    end else begin
      r_s1_vld <= w_close;
      if (w_close) begin
        r_s1_delta <= w_s1_delta;
        r_s1_flags <= w_s1_flags;
      end
    end
  end

`ifdef PWM_CAPTURE_AVG_EN
  localparam int unsigned SUM_W = DELTA_W + 2;

  logic [DELTA_W-1:0] r_hist [3];
  logic [1:0]         r_fill;
  logic               r_av_vld;
  logic [DELTA_W-1:0] r_av_delta;
  frame_flags_t       r_av_flags;
  logic [SUM_W-1:0]   w_sum;
  logic [DELTA_W-1:0] w_avg;

  // Mean over the accepted deltas so far (1, 2 or 4 terms; 3 reuses the oldest pair twice)
  always_comb begin
    w_sum = SUM_W'(r_s1_delta);
    w_avg = r_s1_delta;
    case (r_fill)
      2'd1: begin
        w_sum = SUM_W'(r_s1_delta) + SUM_W'(r_hist[0]);
        w_avg = DELTA_W'(w_sum >> 1);
      end
      2'd2: begin
        w_sum = (SUM_W'(r_hist[0]) + SUM_W'(r_hist[1])) << 1;
        w_avg = DELTA_W'(w_sum >> 2);
      end
      2'd3: begin
        w_sum = SUM_W'(r_s1_delta) + SUM_W'(r_hist[0]) + SUM_W'(r_hist[1]) + SUM_W'(r_hist[2]);
        w_avg = DELTA_W'(w_sum >> 2);
      end
      default: w_avg = r_s1_delta;
    endcase
  end

  // Averaging stage: history of good-period deltas, emptied on timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist     <= '{default: '0};
      r_fill     <= '0;
      r_av_vld   <= 1'b0;
      r_av_delta <= '0;
      r_av_flags <= '0;
    end else begin
      r_av_vld   <= r_s1_vld;
      r_av_flags <= r_s1_flags;
      r_av_delta <= r_s1_flags.period_err ? r_s1_delta : w_avg;
      if (w_to_hit) begin
        r_fill <= '0;
      end else if (r_s1_vld && !r_s1_flags.period_err) begin
        r_hist[2] <= r_hist[1];
        r_hist[1] <= r_hist[0];
        r_hist[0] <= r_s1_delta;
        if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign w_cv_vld   = r_av_vld;
  assign w_cv_delta = r_av_delta;
  assign w_cv_flags = r_av_flags;
`else
  assign w_cv_vld   = r_s1_vld;
  assign w_cv_delta = r_s1_delta;
  assign w_cv_flags = r_s1_flags;
`endif

  pwm_angle_conv #(
    .DELTA_W (DELTA_W),
    .SCALE   (SCALE)
  ) u_conv (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_vld        (w_cv_vld),
    .i_delta      (w_cv_delta),
    .i_flags      (w_cv_flags),
    .o_angle      (io_bus.angle),
    .o_valid      (io_bus.valid),
    .o_range_err  (io_bus.range_err),
    .o_period_err (io_bus.period_err)
  );

  assign io_bus.timeout = r_timeout;

endmodule
